// File: rtl/load_store_unit_if.sv
// Request/response channel between the MEM pipeline stage (master) and the
// load/store unit (slave).
interface load_store_unit_if #(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDRESS = 6
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [NB_ADDRESS-1:0] req_addr;
    logic [NB_DATA-1:0]    req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [NB_DATA-1:0]    rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store initiator: one request at a time, whole-word reads with local
// byte/halfword extraction, alignment checking and a saturating fault counter.
module load_store_unit #(
    parameter int NB_DATA    = 32,
    parameter int N_ADDRESS  = 64,
    parameter int NB_ADDRESS = $clog2(N_ADDRESS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    load_store_unit_if.slave      bus,
    output logic [7:0]            o_err_cnt,
    output logic [NB_ADDRESS-1:0] o_mem_r_addr,
    output logic                  o_mem_r_en,
    output logic [1:0]            o_mem_r_addressing,
    input  logic [NB_DATA-1:0]    i_mem_r_data,
    output logic [NB_ADDRESS-1:0] o_mem_w_addr,
    output logic [NB_DATA-1:0]    o_mem_w_data,
    output logic                  o_mem_w_en,
    output logic [1:0]            o_mem_w_addressing
);

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_ILL  = 2'b10;
    localparam logic [1:0] SIZE_BYTE = 2'b11;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state_reg;
    logic                  we_reg;
    logic [1:0]            size_reg;
    logic                  unsigned_reg;
    logic [NB_ADDRESS-1:0] addr_reg;
    logic [NB_DATA-1:0]    wdata_reg;
    logic [NB_DATA-1:0]    rdata_reg;
    logic                  err_reg;
    logic [7:0]            err_cnt_reg;

    logic                  access_err;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic [NB_DATA-1:0]    load_next;

    always_comb begin
        access_err = (size_reg == SIZE_ILL)
                   | ((size_reg == SIZE_WORD) & (addr_reg[1:0] != 2'b00))
                   | ((size_reg == SIZE_HALF) & addr_reg[0]);
    end

    // Memory always returns the aligned word; pick the lane by low address bits.
    always_comb begin
        byte_lane = i_mem_r_data[{addr_reg[1:0], 3'b000} +: 8];
        half_lane = i_mem_r_data[{addr_reg[1], 4'b0000} +: 16];
        case (size_reg)
            SIZE_BYTE: load_next = {{24{~unsigned_reg & byte_lane[7]}}, byte_lane};
            SIZE_HALF: load_next = {{16{~unsigned_reg & half_lane[15]}}, half_lane};
            default:   load_next = i_mem_r_data;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg    <= IDLE;
            we_reg       <= 1'b0;
            size_reg     <= SIZE_WORD;
            unsigned_reg <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
            err_cnt_reg  <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_reg       <= bus.req_we;
                        size_reg     <= bus.req_size;
                        unsigned_reg <= bus.req_unsigned;
                        addr_reg     <= bus.req_addr;
                        wdata_reg    <= bus.req_wdata;
                        state_reg    <= ACCESS;
                    end
                end
                ACCESS: begin
                    state_reg <= RESP;
                    err_reg   <= access_err;
                    if (access_err) begin
                        rdata_reg <= '0;
                        if (err_cnt_reg != 8'hFF) begin
                            err_cnt_reg <= err_cnt_reg + 8'd1;
                        end
                    end else if (we_reg) begin
                        rdata_reg <= '0;
                    end else begin
                        rdata_reg <= load_next;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state_reg == IDLE);
    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_rdata = rdata_reg;
    assign bus.rsp_err   = err_reg;
    assign o_err_cnt     = err_cnt_reg;

    // Write strobe is gated by reset so a store caught by reset never commits.
    assign o_mem_w_en         = i_rst_n & (state_reg == ACCESS) & we_reg & ~access_err;
    assign o_mem_w_addr       = addr_reg;
    assign o_mem_w_data       = wdata_reg;
    assign o_mem_w_addressing = size_reg;

    assign o_mem_r_en         = (state_reg == ACCESS) & ~we_reg & ~access_err;
    assign o_mem_r_addr       = {addr_reg[NB_ADDRESS-1:2], 2'b00};
    assign o_mem_r_addressing = 2'b00;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a 64-byte behavioural memory.
module tb_load_store_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [7:0]  err_cnt;
    logic [5:0]  mem_r_addr, mem_w_addr;
    logic        mem_r_en, mem_w_en;
    logic [1:0]  mem_r_addressing, mem_w_addressing;
    logic [31:0] mem_r_data, mem_w_data;

    load_store_unit_if #(.NB_DATA(32), .NB_ADDRESS(6)) bus_if ();

    load_store_unit dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .bus                (bus_if),
        .o_err_cnt          (err_cnt),
        .o_mem_r_addr       (mem_r_addr),
        .o_mem_r_en         (mem_r_en),
        .o_mem_r_addressing (mem_r_addressing),
        .i_mem_r_data       (mem_r_data),
        .o_mem_w_addr       (mem_w_addr),
        .o_mem_w_data       (mem_w_data),
        .o_mem_w_en         (mem_w_en),
        .o_mem_w_addressing (mem_w_addressing)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural memory driven by the DUT; ref_mem is the bench's own model.
    logic [7:0] mem     [0:63];
    logic [7:0] ref_mem [0:63];
    bit         mem_init_done;

    assign mem_r_data = {mem[mem_r_addr + 6'd3], mem[mem_r_addr + 6'd2],
                         mem[mem_r_addr + 6'd1], mem[mem_r_addr]};

    always @(posedge i_clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'(i * 7 + 3);
            mem_init_done <= 1'b1;
        end else if (mem_w_en === 1'b1) begin
            mem[mem_w_addr] <= mem_w_data[7:0];
            if (mem_w_addressing != 2'b11) mem[mem_w_addr + 6'd1] <= mem_w_data[15:8];
            if (mem_w_addressing == 2'b00) begin
                mem[mem_w_addr + 6'd2] <= mem_w_data[23:16];
                mem[mem_w_addr + 6'd3] <= mem_w_data[31:24];
            end
        end
    end

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_cnt = 8'd0;
    logic        exp_err;
    logic [31:0] last_rdata;

    task automatic model_push(input logic we, input logic [1:0] size, input logic uns,
                              input logic [5:0] addr, input logic [31:0] wdata);
        exp_t        e;
        logic [7:0]  b;
        logic [15:0] h;
        logic [5:0]  base;
        exp_err = (size == 2'b10) || (size == 2'b00 && addr[1:0] != 2'b00) ||
                  (size == 2'b01 && addr[0]);
        e.err   = exp_err;
        e.rdata = 32'd0;
        if (exp_err) begin
            if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
        end else if (we) begin
            ref_mem[addr] = wdata[7:0];
            if (size != 2'b11) ref_mem[addr + 1] = wdata[15:8];
            if (size == 2'b00) begin
                ref_mem[addr + 2] = wdata[23:16];
                ref_mem[addr + 3] = wdata[31:24];
            end
        end else begin
            b    = ref_mem[addr];
            h    = {ref_mem[addr + 1], ref_mem[addr]};
            base = addr;
            if (size == 2'b11)      e.rdata = uns ? {24'd0, b} : {{24{b[7]}}, b};
            else if (size == 2'b01) e.rdata = uns ? {16'd0, h} : {{16{h[15]}}, h};
            else e.rdata = {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
        end
        e.cnt = exp_cnt;
        sb_q.push_back(e);
    endtask

    // Called just after a falling edge; returns just after the falling edge in RESP.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [5:0] addr, input logic [31:0] wdata);
        int waited = 0;
        bus_if.req_we       = we;
        bus_if.req_size     = size;
        bus_if.req_unsigned = uns;
        bus_if.req_addr     = addr;
        bus_if.req_wdata    = wdata;
        bus_if.req_valid    = 1'b1;
        while (bus_if.req_ready !== 1'b1 && waited < 20) begin
            @(negedge i_clk);
            waited++;
        end
        if (waited >= 20) begin
            $display("FAIL accept_timeout: req_ready=%b required 1", bus_if.req_ready);
            $fatal(1, "request never accepted");
        end
        model_push(we, size, uns, addr, wdata);
        @(negedge i_clk);
        bus_if.req_valid = 1'b0;
        n_tests++;
        if ({mem_r_en, mem_w_en} !== {~we & ~exp_err, we & ~exp_err}) begin
            n_fail++;
            $display("FAIL strobes addr=%0d: r_en,w_en=%b%b required %b%b", addr,
                     mem_r_en, mem_w_en, ~we & ~exp_err, we & ~exp_err);
        end
        if (!exp_err) begin
            n_tests++;
            if (we && {mem_w_addr, mem_w_data, mem_w_addressing} !== {addr, wdata, size}) begin
                n_fail++;
                $display("FAIL wport: addr=%0d data=%h sz=%b required addr=%0d data=%h sz=%b",
                         mem_w_addr, mem_w_data, mem_w_addressing, addr, wdata, size);
            end
            if (!we && {mem_r_addr, mem_r_addressing} !== {addr[5:2], 2'b00, 2'b00}) begin
                n_fail++;
                $display("FAIL rport: addr=%0d sz=%b required addr=%0d sz=00",
                         mem_r_addr, mem_r_addressing, {addr[5:2], 2'b00});
            end
        end
        n_tests++;
        if (bus_if.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_in_access: got %b required 0", bus_if.req_ready);
        end
        @(negedge i_clk);
    endtask

    // Checks the response, optionally holding it, and completes the handshake.
    task automatic collect(input int hold, input bit chain);
        exp_t e;
        n_tests++;
        if (bus_if.rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL latency: rsp_valid=%b required 1 two cycles after accept", bus_if.rsp_valid);
        end
        if (sb_q.size() == 0) begin
            $display("FAIL scoreboard_empty: no expected entry");
            $fatal(1, "scoreboard underflow");
        end
        e = sb_q.pop_front();
        n_tests++;
        if ({bus_if.rsp_rdata, bus_if.rsp_err, err_cnt} !== {e.rdata, e.err, e.cnt}) begin
            n_fail++;
            $display("FAIL rsp: rdata=%h err=%b cnt=%0d required rdata=%h err=%b cnt=%0d",
                     bus_if.rsp_rdata, bus_if.rsp_err, err_cnt, e.rdata, e.err, e.cnt);
        end
        last_rdata = bus_if.rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            bus_if.req_valid = ~i[0];
            bus_if.req_we    = i[0];
            @(negedge i_clk);
            n_tests++;
            if ({bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_err, bus_if.req_ready} !==
                {1'b1, e.rdata, e.err, 1'b0}) begin
                n_fail++;
                $display("FAIL hold%0d: valid=%b rdata=%h err=%b ready=%b required 1 %h %b 0", i,
                         bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_err, bus_if.req_ready,
                         e.rdata, e.err);
            end
        end
        bus_if.req_valid = chain;
        bus_if.rsp_ready = 1'b1;
        @(negedge i_clk);
        bus_if.rsp_ready = 1'b0;
        n_tests++;
        if ({bus_if.rsp_valid, bus_if.req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL release: rsp_valid=%b req_ready=%b required 0 1",
                     bus_if.rsp_valid, bus_if.req_ready);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        n_tests++;
        if ({bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_err, err_cnt, bus_if.req_ready,
             mem_r_en, mem_w_en} !== {1'b0, 32'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: valid=%b rdata=%h err=%b cnt=%0d ready=%b r_en=%b w_en=%b required 0 0 0 0 1 0 0",
                     bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_err, err_cnt,
                     bus_if.req_ready, mem_r_en, mem_w_en);
        end
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_store_load();
        issue(1'b1, 2'b00, 1'b0, 6'd8, 32'hDEADBEEF);
        collect(0, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 6'd8, 32'd0);
        collect(0, 1'b0);
        n_tests++;
        if (last_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL load_word8: got %h required deadbeef", last_rdata);
        end
    endtask

    task automatic test_extract();
        logic [1:0]  sz_t [4] = '{2'b11, 2'b11, 2'b01, 2'b01};
        logic [5:0]  ad_t [4] = '{6'd9, 6'd9, 6'd10, 6'd10};
        logic [31:0] rd_t [4] = '{32'hFFFFFFBE, 32'h000000BE, 32'hFFFFDEAD, 32'h0000DEAD};
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, sz_t[i], i[0], ad_t[i], 32'd0);
            collect(0, 1'b0);
            n_tests++;
            if (last_rdata !== rd_t[i]) begin
                n_fail++;
                $display("FAIL extract%0d: got %h required %h", i, last_rdata, rd_t[i]);
            end
        end
        for (int a = 8; a < 12; a++) begin
            issue(1'b0, 2'b11, 1'b0, 6'(a), 32'd0);
            collect(0, 1'b0);
        end
    endtask

    task automatic test_byte_store();
        issue(1'b1, 2'b11, 1'b0, 6'd11, 32'h0000005A);
        collect(0, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 6'd8, 32'd0);
        collect(0, 1'b0);
        n_tests++;
        if (last_rdata !== 32'h5AADBEEF) begin
            n_fail++;
            $display("FAIL byte_store: got %h required 5aadbeef", last_rdata);
        end
    endtask

    task automatic test_faults();
        issue(1'b0, 2'b00, 1'b0, 6'd6, 32'd0);
        collect(0, 1'b0);
        issue(1'b1, 2'b01, 1'b0, 6'd3, 32'hCAFEF00D);
        collect(0, 1'b0);
        n_tests++;
        if ({mem[0], mem[1], mem[2], mem[3], mem[4]} !==
            {ref_mem[0], ref_mem[1], ref_mem[2], ref_mem[3], ref_mem[4]}) begin
            n_fail++;
            $display("FAIL fault_mem: got %h%h%h%h%h required %h%h%h%h%h",
                     mem[0], mem[1], mem[2], mem[3], mem[4],
                     ref_mem[0], ref_mem[1], ref_mem[2], ref_mem[3], ref_mem[4]);
        end
        issue(1'b0, 2'b10, 1'b0, 6'd0, 32'd0);
        collect(0, 1'b0);
    endtask

    task automatic test_backpressure();
        issue(1'b0, 2'b00, 1'b0, 6'd8, 32'd0);
        collect(5, 1'b0);
        n_tests++;
        @(negedge i_clk);
        if ({bus_if.rsp_valid, bus_if.req_ready, mem_r_en, mem_w_en} !== 4'b0100) begin
            n_fail++;
            $display("FAIL ignored_req: valid=%b ready=%b r_en=%b w_en=%b required 0 1 0 0",
                     bus_if.rsp_valid, bus_if.req_ready, mem_r_en, mem_w_en);
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 2'b11, 1'b1, 6'd9, 32'd0);
        collect(0, 1'b1);
        issue(1'b0, 2'b11, 1'b1, 6'd9, 32'd0);
        collect(0, 1'b0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            issue(1'b0, 2'b01, 1'b0, 6'(2 * i + 1), 32'd0);
            collect(0, 1'b0);
        end
        n_tests++;
        if (err_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL saturation: got %0d required 255", err_cnt);
        end
    endtask

    task automatic test_reset_in_access();
        int waited = 0;
        bus_if.req_we = 1'b1; bus_if.req_size = 2'b00; bus_if.req_unsigned = 1'b0;
        bus_if.req_addr = 6'd16; bus_if.req_wdata = 32'h11223344; bus_if.req_valid = 1'b1;
        while (bus_if.req_ready !== 1'b1 && waited < 20) begin
            @(negedge i_clk);
            waited++;
        end
        @(negedge i_clk);
        bus_if.req_valid = 1'b0;
        n_tests++;
        if (mem_w_en !== 1'b1) begin
            n_fail++;
            $display("FAIL store_strobe: w_en=%b required 1", mem_w_en);
        end
        i_rst_n = 1'b0;
        #1;
        n_tests++;
        if (mem_w_en !== 1'b0) begin
            n_fail++;
            $display("FAIL w_en_gated: got %b required 0", mem_w_en);
        end
        @(negedge i_clk);
        n_tests++;
        if ({bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_err, err_cnt, bus_if.req_ready,
             mem_r_en, mem_w_en} !== {1'b0, 32'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_access: valid=%b rdata=%h err=%b cnt=%0d ready=%b r_en=%b w_en=%b required 0 0 0 0 1 0 0",
                     bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_err, err_cnt,
                     bus_if.req_ready, mem_r_en, mem_w_en);
        end
        i_rst_n = 1'b1;
        exp_cnt = 8'd0;
        sb_q.delete();
        @(negedge i_clk);
        issue(1'b0, 2'b00, 1'b0, 6'd16, 32'd0);
        collect(0, 1'b0);
        n_tests++;
        if (last_rdata !== 32'h88817A73) begin
            n_fail++;
            $display("FAIL old_value16: got %h required 88817a73", last_rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i * 7 + 3);
        i_rst_n             = 1'b0;
        bus_if.req_valid    = 1'b0;
        bus_if.req_we       = 1'b0;
        bus_if.req_size     = 2'b00;
        bus_if.req_unsigned = 1'b0;
        bus_if.req_addr     = 6'd0;
        bus_if.req_wdata    = 32'd0;
        bus_if.rsp_ready    = 1'b0;
        @(negedge i_clk);
        test_reset();
        test_store_load();
        test_extract();
        test_byte_store();
        test_faults();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_reset_in_access();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
